// File: rtl/spectrum_frame_scheduler_pkg.sv
// Shared types and sizes for the spectrum frame scheduler slice.
// Pure declarations: no logic, no latency, no flow control.
package spectrum_pkg;
  localparam int NUM_BINS = 16;
  localparam int DATA_W   = 16;

  typedef logic [DATA_W-1:0]   bin_t;
  typedef bin_t [NUM_BINS-1:0] bins_t;
  typedef logic [3:0]          hold_t;
  typedef logic [3:0]          idx_t;

  typedef enum logic [1:0] {
    IDLE,
    PROCESS,
    WAIT_VBLANK
  } state_t;
endpackage

// File: rtl/spectrum_frame_scheduler_if.sv
// FFT-in / renderer-out bundle of the frame scheduler; master drives FFT and scan line.
// Wires only: no latency; no backpressure, since dropped frames are only counted.
interface spectrum_frame_scheduler_if;
  import spectrum_pkg::*;

  bins_t       i_fft_data;
  logic        i_fft_done;
  logic [10:0] i_VGA_Y;
  bins_t       o_level_data;
  bins_t       o_peak_data;
  logic        o_frame_commit;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;

  modport master (
    output i_fft_data, i_fft_done, i_VGA_Y,
    input  o_level_data, o_peak_data, o_frame_commit, o_busy, o_drop_cnt
  );

  modport slave (
    input  i_fft_data, i_fft_done, i_VGA_Y,
    output o_level_data, o_peak_data, o_frame_commit, o_busy, o_drop_cnt
  );
endinterface

// File: rtl/spectrum_frame_scheduler_bin_update.sv
// Magnitude, level decay and peak-hold for one bin; purely combinational.
// Zero latency, no backpressure; the caller time-shares one instance across bins.
module spectrum_bin_update
  import spectrum_pkg::*;
#(
  parameter int DECAY_STEP  = 256,
  parameter int HOLD_FRAMES = 4
) (
  input  bin_t  x,
  input  bin_t  level,
  input  bin_t  peak,
  input  hold_t hold,
  output bin_t  level_nxt,
  output bin_t  peak_nxt,
  output hold_t hold_nxt
);
  localparam bin_t  STEP    = bin_t'(DECAY_STEP);
  localparam hold_t HOLD    = hold_t'(HOLD_FRAMES);
  localparam bin_t  MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam bin_t  MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  bin_t mag, level_dec, peak_dec;

  always_comb begin
    mag       = x;
    level_dec = '0;
    peak_dec  = '0;
    level_nxt = '0;
    peak_nxt  = '0;
    hold_nxt  = '0;

    // The most negative input has no positive twin, so it clips to full scale.
    if (x[DATA_W-1]) begin
      mag = (x == MIN_NEG) ? MAX_POS : bin_t'(-x);
    end

    level_dec = (level >= STEP) ? level - STEP : '0;
    peak_dec  = (peak  >= STEP) ? peak  - STEP : '0;
    level_nxt = (mag > level_dec) ? mag : level_dec;

    if (mag >= peak) begin
      peak_nxt = mag;
      hold_nxt = HOLD;
    end else if (hold != '0) begin
      peak_nxt = peak;
      hold_nxt = hold - 1'b1;
    end else begin
      peak_nxt = (mag > peak_dec) ? mag : peak_dec;
      hold_nxt = '0;
    end
  end
endmodule

// File: rtl/spectrum_frame_scheduler.sv
// Decimates FFT frames, updates level/peak one bin per cycle, commits during vertical blanking.
// Commit lands 18 cycles after an accepted strobe at the earliest; strobes arriving while busy are dropped and counted.
module spectrum_frame_scheduler
  import spectrum_pkg::*;
#(
  parameter int DECIM       = 8,
  parameter int DECAY_STEP  = 256,
  parameter int HOLD_FRAMES = 4,
  parameter int V_ACTIVE    = 480
) (
  input logic                        i_clk,
  input logic                        i_rst,
  spectrum_frame_scheduler_if.slave  bus
);
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t                  state, state_nxt;
  logic [DEC_W-1:0]        dec_cnt;
  idx_t                    b;
  bins_t                   shadow, level_stg, peak_stg, level_q, peak_q;
  hold_t [NUM_BINS-1:0]    hold_stg;
  logic                    commit_q;
  logic [7:0]              drop_cnt;
  logic                    accept, upd_en, commit;
  bin_t                    level_nxt, peak_nxt;
  hold_t                   hold_nxt;

  spectrum_bin_update #(
    .DECAY_STEP  (DECAY_STEP),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_bin_update (
    .x         (shadow[b]),
    .level     (level_stg[b]),
    .peak      (peak_stg[b]),
    .hold      (hold_stg[b]),
    .level_nxt (level_nxt),
    .peak_nxt  (peak_nxt),
    .hold_nxt  (hold_nxt)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    upd_en    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_fft_done && dec_cnt == '0) begin
          accept    = 1'b1;
          state_nxt = PROCESS;
        end
      end
      PROCESS: begin
        upd_en = 1'b1;
        if (b == idx_t'(NUM_BINS-1)) state_nxt = WAIT_VBLANK;
      end
      WAIT_VBLANK: begin
        if (bus.i_VGA_Y >= 11'(V_ACTIVE)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dec_cnt   <= '0;
      b         <= '0;
      shadow    <= '0;
      level_stg <= '0;
      peak_stg  <= '0;
      hold_stg  <= '0;
      level_q   <= '0;
      peak_q    <= '0;
      commit_q  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      commit_q <= commit;
      // Only strobes seen in IDLE advance decimation; busy strobes just bump the drop count.
      if (bus.i_fft_done && state == IDLE) begin
        dec_cnt <= (dec_cnt == DEC_W'(DECIM-1)) ? '0 : dec_cnt + 1'b1;
      end
      if (bus.i_fft_done && state != IDLE && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (accept) begin
        shadow <= bus.i_fft_data;
        b      <= '0;
      end else if (upd_en) begin
        level_stg[b] <= level_nxt;
        peak_stg[b]  <= peak_nxt;
        hold_stg[b]  <= hold_nxt;
        b            <= b + 1'b1;
      end
      if (commit) begin
        level_q <= level_stg;
        peak_q  <= peak_stg;
      end
    end
  end

  assign bus.o_level_data   = level_q;
  assign bus.o_peak_data    = peak_q;
  assign bus.o_frame_commit = commit_q;
  assign bus.o_busy         = (state != IDLE);
  assign bus.o_drop_cnt     = drop_cnt;
endmodule
